abc_max_pulse: RTL and testbench

- Two-input consumer with independent dav_/rfd handshakes on channels X and Y.
- Captures one 8-bit unsigned byte from each channel.
- Emits a single high pulse on out whose length in clock cycles equals max(x,y).
- Then reopens both channels for the next pair; sits between two byte producers and a pulse-width-measuring consumer.

---
 rtl/abc_pkg.sv | 12 +
 rtl/abc_pulse_gen.sv | 39 +++
 rtl/abc_max_pulse.sv | 113 +++++++++++
 tb/tb_abc_max_pulse.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/abc_pkg.sv
// Shared constants and FSM state encoding for the abc_max_pulse block.
package abc_pkg;

    localparam int WIDTH_DEF = 8;

    typedef enum logic [1:0] {
        S_ACQ,
        S_CLOSE,
        S_PULSE
    } state_t;

endpackage

// File: rtl/abc_pulse_gen.sv
// Down-counter pulse generator: start loads len, out stays high for len cycles.
// done flags the final high cycle so the owner can act on the falling edge.
module abc_pulse_gen
    import abc_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic             clock,
    input  logic             reset_,
    input  logic             start,
    input  logic [WIDTH-1:0] len,
    output logic             out,
    output logic             done
);

    logic [WIDTH-1:0] cnt;

    assign done = out && (cnt == WIDTH'(1));

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge clock or negedge reset_) begin
        if (!reset_) begin
            cnt <= '0;
            out <= 1'b0;
        end else if (start) begin
            cnt <= len;
            out <= (len != '0);
        end else if (out) begin
            if (cnt == WIDTH'(1)) begin
                cnt <= '0;
                out <= 1'b0;
            end else begin
                cnt <= cnt - WIDTH'(1);
            end
        end
    end

endmodule

// File: rtl/abc_max_pulse.sv
// Two-channel dav_/rfd byte consumer; emits one pulse of width max(x,y).
// Build option: define ABC_MIN_SELECT_EN to use min(x,y) for the width instead.
module abc_max_pulse
    import abc_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic             clock,
    input  logic             reset_,
    input  logic             dav_x,
    input  logic [WIDTH-1:0] x,
    output logic             rfd_x,
    input  logic             dav_y,
    input  logic [WIDTH-1:0] y,
    output logic             rfd_y,
    output logic             out
);

    state_t           state, state_nxt;
    logic [WIDTH-1:0] xr, yr, sel;
    logic             x_got, y_got, x_got_nxt, y_got_nxt;
    logic             rfd_x_nxt, rfd_y_nxt;
    logic             cap_x, cap_y, start, done;

`ifdef ABC_MIN_SELECT_EN
    assign sel = (xr < yr) ? xr : yr;
`else
    assign sel = (xr > yr) ? xr : yr;
`endif

    always_ff @(posedge clock or negedge reset_) begin
        if (!reset_) begin
            state <= S_ACQ;
            rfd_x <= 1'b1;
            rfd_y <= 1'b1;
            x_got <= 1'b0;
            y_got <= 1'b0;
            xr    <= '0;
            yr    <= '0;
        end else begin
            state <= state_nxt;
            rfd_x <= rfd_x_nxt;
            rfd_y <= rfd_y_nxt;
            x_got <= x_got_nxt;
            y_got <= y_got_nxt;
            if (cap_x) xr <= x;
            if (cap_y) yr <= y;
        end
    end

    // NOTE: every always_comb output gets a default first, so no path through
    // the case can leave a signal unassigned and infer a latch.
    always_comb begin
        state_nxt = state;
        rfd_x_nxt = rfd_x;
        rfd_y_nxt = rfd_y;
        x_got_nxt = x_got;
        y_got_nxt = y_got;
        cap_x     = 1'b0;
        cap_y     = 1'b0;
        start     = 1'b0;
        case (state)
            S_ACQ: begin
                cap_x = rfd_x && !dav_x;
                cap_y = rfd_y && !dav_y;
                if (cap_x) begin
                    rfd_x_nxt = 1'b0;
                    x_got_nxt = 1'b1;
                end
                if (cap_y) begin
                    rfd_y_nxt = 1'b0;
                    y_got_nxt = 1'b1;
                end
                if (x_got_nxt && y_got_nxt) state_nxt = S_CLOSE;
            end
            S_CLOSE: begin
                // Both producers must withdraw dav_ before the pulse begins.
                if (dav_x && dav_y) begin
                    start = 1'b1;
                    if (sel != '0) begin
                        state_nxt = S_PULSE;
                    end else begin
                        state_nxt = S_ACQ;
                        rfd_x_nxt = 1'b1;
                        rfd_y_nxt = 1'b1;
                        x_got_nxt = 1'b0;
                        y_got_nxt = 1'b0;
                    end
                end
            end
            S_PULSE: begin
                if (done) begin
                    state_nxt = S_ACQ;
                    rfd_x_nxt = 1'b1;
                    rfd_y_nxt = 1'b1;
                    x_got_nxt = 1'b0;
                    y_got_nxt = 1'b0;
                end
            end
            default: state_nxt = S_ACQ;
        endcase
    end

    abc_pulse_gen #(.WIDTH(WIDTH)) u_pulse_gen (
        .clock  (clock),
        .reset_ (reset_),
        .start  (start),
        .len    (sel),
        .out    (out),
        .done   (done)
    );

endmodule

// File: tb/tb_abc_max_pulse.sv
// Directed bench for abc_max_pulse: handshakes on both channels, measured pulse widths.
module tb_abc_max_pulse;

    logic       clock;
    logic       reset_;
    logic       dav_x, dav_y;
    logic [7:0] x, y;
    logic       rfd_x, rfd_y, out;

    int checks   = 0;
    int failures = 0;
    int run_len  = 0;
    int overlap  = 0;
    int widths[$];

    abc_max_pulse #(.WIDTH(8)) dut (
        .clock  (clock),
        .reset_ (reset_),
        .dav_x  (dav_x),
        .x      (x),
        .rfd_x  (rfd_x),
        .dav_y  (dav_y),
        .y      (y),
        .rfd_y  (rfd_y),
        .out    (out)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Pulse width = number of falling edges at which out was seen high.
    always @(negedge clock) begin
        if (!reset_) begin
            run_len = 0;
        end else if (out === 1'b1) begin
            run_len++;
            if (rfd_x !== 1'b0 || rfd_y !== 1'b0) overlap++;
        end else if (run_len > 0) begin
            widths.push_back(run_len);
            run_len = 0;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int exp_w(input int a, input int b);
`ifdef ABC_MIN_SELECT_EN
        return (a < b) ? a : b;
`else
        return (a > b) ? a : b;
`endif
    endfunction

    task automatic drive_x(input logic [7:0] v, input int pre);
        int n;
        repeat (pre) @(negedge clock);
        n = 0;
        while (rfd_x !== 1'b1 && n < 1000) begin @(negedge clock); n++; end
        if (rfd_x !== 1'b1) check("x_rfd_wait_timeout", 0, 1);
        dav_x = 1'b0;
        x     = v;
        n = 0;
        do begin @(negedge clock); n++; end while (rfd_x !== 1'b0 && n < 1000);
        if (rfd_x !== 1'b0) check("x_capture_timeout", 0, 1);
        dav_x = 1'b1;
        x     = 'x;
    endtask

    task automatic drive_y(input logic [7:0] v, input int pre);
        int n;
        repeat (pre) @(negedge clock);
        n = 0;
        while (rfd_y !== 1'b1 && n < 1000) begin @(negedge clock); n++; end
        if (rfd_y !== 1'b1) check("y_rfd_wait_timeout", 0, 1);
        dav_y = 1'b0;
        y     = v;
        n = 0;
        do begin @(negedge clock); n++; end while (rfd_y !== 1'b0 && n < 1000);
        if (rfd_y !== 1'b0) check("y_capture_timeout", 0, 1);
        dav_y = 1'b1;
        y     = 'x;
    endtask

    task automatic wait_pulse(input int exp, input string tag);
        int n;
        n = 0;
        while (widths.size() == 0 && n < 2000) begin @(negedge clock); #1; n++; end
        if (widths.size() == 0) begin
            check({tag, "_timeout"}, 0, 1);
        end else begin
            check(tag, widths.pop_front(), exp);
            check({tag, "_rfd_reopen"}, {rfd_x, rfd_y}, 2'b11);
        end
    endtask

    task automatic do_pair(input int xv, input int yv, input int px, input int py, input string tag);
        int e;
        e = exp_w(xv, yv);
        fork
            drive_x(8'(xv), px);
            drive_y(8'(yv), py);
        join
        if (e == 0) begin
            @(negedge clock); #1;
            check({tag, "_rfd_reopen"}, {rfd_x, rfd_y, out}, 3'b110);
            repeat (4) @(negedge clock);
            #1;
            check({tag, "_no_pulse"}, widths.size(), 0);
        end else begin
            wait_pulse(e, tag);
        end
    endtask

    initial begin
        int n;
        reset_ = 1'b0;
        dav_x  = 1'b1;
        dav_y  = 1'b1;
        x      = 'x;
        y      = 'x;
        repeat (3) @(negedge clock);
        reset_ = 1'b1;
        #1;
        check("reset_state", {rfd_x, rfd_y, out}, 3'b110);

        do_pair(5, 12, 1, 6, "x5_y12_slow_y");
        do_pair(12, 5, 0, 2, "x12_y5");
        do_pair(33, 20, 3, 0, "x33_y20");
        do_pair(15, 15, 0, 0, "equal_15");
        do_pair(0, 0, 0, 1, "zero_pair");

        // Both channels presented on the same edge.
        @(negedge clock);
        dav_x = 1'b0; x = 8'd40;
        dav_y = 1'b0; y = 8'd7;
        @(negedge clock); #1;
        check("simul_rfd_fall", {rfd_x, rfd_y}, 2'b00);
        dav_x = 1'b1; x = 'x;
        dav_y = 1'b1; y = 'x;
        wait_pulse(exp_w(40, 7), "simul_40_7");

        for (int k = 0; k < 32; k++) begin
            int a, b;
            a = (k + 4) * 3;
            b = (k + 1) * 5;
            if (k % 2 == 1) do_pair(b, a, 0, 0, "b2b_pair");
            else            do_pair(a, b, 0, 0, "b2b_pair");
        end

        // Asynchronous reset in the middle of a long pulse.
        fork
            drive_x(8'd100, 0);
            drive_y(8'd3, 0);
        join
        n = 0;
        while (out !== 1'b1 && n < 50) begin @(negedge clock); n++; end
        check("midpulse_started", out, 1'b1);
        repeat (10) @(negedge clock);
        #2 reset_ = 1'b0;
        #1;
        check("async_reset_outputs", {rfd_x, rfd_y, out}, 3'b110);
        repeat (3) @(negedge clock);
        reset_ = 1'b1;
        widths.delete();
        do_pair(9, 4, 0, 1, "after_reset_9_4");

        check("rfd_low_during_pulse", overlap, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
